// File: rtl/shift_pkg.sv
// Shared encodings for the sequential shifter: shift modes and controller states.
package shift_pkg;

  typedef enum logic [1:0] {
    MODE_LSR = 2'b00,
    MODE_ASR = 2'b01,
    MODE_LSL = 2'b10,
    MODE_ROR = 2'b11
  } shift_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit shift/rotate step used once per SHIFT cycle.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] data_o
);

  always_comb begin
    data_o = data_i;
    case (shift_mode_e'(mode))
      MODE_LSR: data_o = {1'b0, data_i[WIDTH-1:1]};
      MODE_ASR: data_o = {data_i[WIDTH-1], data_i[WIDTH-1:1]};
      MODE_LSL: data_o = {data_i[WIDTH-2:0], 1'b0};
      MODE_ROR: data_o = {data_i[0], data_i[WIDTH-1:1]};
      default:  data_o = data_i;
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shifter: latches an operand, applies one 1-bit step per cycle
// for the requested amount, then pulses done for a single cycle.
module seq_shifter
  import shift_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [SHW-1:0]   amt,
  input  logic [WIDTH-1:0] din,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout
);

  localparam int unsigned MAX_AMT = WIDTH - 1;

  state_e           state_q, state_d;
  shift_mode_e      mode_q,  mode_d;
  logic [SHW-1:0]   count_q, count_d;
  logic [WIDTH-1:0] dout_q,  dout_d;
  logic [SHW-1:0]   amt_lim;
  logic [WIDTH-1:0] step_data;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .data_i (dout_q),
    .mode   (mode_q),
    .data_o (step_data)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d = state_q;
    mode_d  = mode_q;
    count_d = count_q;
    dout_d  = dout_q;
    // Out-of-range amounts only exist when WIDTH is not a power of two.
    amt_lim = (32'(amt) > MAX_AMT) ? SHW'(MAX_AMT) : amt;

    case (state_q)
      IDLE: begin
        if (start) begin
          dout_d  = din;
          mode_d  = shift_mode_e'(mode);
          count_d = amt_lim;
          state_d = (amt_lim != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        dout_d  = step_data;
        count_d = count_q - SHW'(1);
        if (count_q == SHW'(1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= MODE_LSR;
      count_q <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      count_q <= count_d;
      dout_q  <= dout_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign dout = dout_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Directed bench for seq_shifter at WIDTH 4, 8 and 5 (the last exercises amount clamping).
module tb_seq_shifter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start4, busy4, done4;
  logic [1:0] mode4, amt4;
  logic [3:0] din4, dout4;
  logic       start8, busy8, done8;
  logic [1:0] mode8;
  logic [2:0] amt8;
  logic [7:0] din8, dout8;
  logic       start5, busy5, done5;
  logic [1:0] mode5;
  logic [2:0] amt5;
  logic [4:0] din5, dout5;

  int errors = 0;
  int checks = 0;

  seq_shifter #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .mode(mode4), .amt(amt4), .din(din4),
    .busy(busy4), .done(done4), .dout(dout4)
  );
  seq_shifter #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .mode(mode8), .amt(amt8), .din(din8),
    .busy(busy8), .done(done8), .dout(dout8)
  );
  seq_shifter #(.WIDTH(5)) u_dut5 (
    .clk(clk), .rst(rst), .start(start5), .mode(mode5), .amt(amt5), .din(din5),
    .busy(busy5), .done(done5), .dout(dout5)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int sel, input logic st, input logic [1:0] m,
                       input logic [7:0] a, input logic [7:0] d);
    case (sel)
      0: begin start4 = st; mode4 = m; amt4 = a[1:0]; din4 = d[3:0]; end
      1: begin start8 = st; mode8 = m; amt8 = a[2:0]; din8 = d;      end
      default: begin start5 = st; mode5 = m; amt5 = a[2:0]; din5 = d[4:0]; end
    endcase
  endtask

  function automatic logic get_busy(input int sel);
    return (sel == 0) ? busy4 : (sel == 1) ? busy8 : busy5;
  endfunction

  function automatic logic get_done(input int sel);
    return (sel == 0) ? done4 : (sel == 1) ? done8 : done5;
  endfunction

  function automatic logic [7:0] get_dout(input int sel);
    return (sel == 0) ? {4'b0, dout4} : (sel == 1) ? dout8 : {3'b0, dout5};
  endfunction

  // One start pulse, then scrambled inputs while the operation runs; optional
  // re-pulse of start (with a different din) at SHIFT cycle repulse_at.
  task automatic run_op(input string tag, input int sel, input logic [1:0] m,
                        input logic [7:0] a, input logic [7:0] d,
                        input int exp_lat, input logic [7:0] exp, input int repulse_at);
    int n;
    int busy_n;
    @(negedge clk);
    drive(sel, 1'b1, m, a, d);
    @(negedge clk);
    drive(sel, 1'b0, ~m, ~a, ~d);
    n = 1;
    busy_n = 0;
    while (n <= 64) begin
      if (get_busy(sel)) busy_n++;
      if (get_done(sel)) break;
      if (n == repulse_at) drive(sel, 1'b1, m, a, 8'h01);
      else                 drive(sel, 1'b0, ~m, ~a, ~d);
      @(negedge clk);
      n++;
    end
    drive(sel, 1'b0, ~m, ~a, ~d);
    check({tag, "_latency"}, 64'(n), 64'(exp_lat));
    check({tag, "_dout"}, 64'(get_dout(sel)), 64'(exp));
    check({tag, "_busy_cycles"}, 64'(busy_n), 64'(exp_lat));
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 64'(get_done(sel)), 64'(0));
    check({tag, "_idle_busy"}, 64'(get_busy(sel)), 64'(0));
    check({tag, "_hold"}, 64'(get_dout(sel)), 64'(exp));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;
    rst = 1'b1;
    for (int s = 0; s < 3; s++) drive(s, 1'b0, 2'b00, 8'h00, 8'h00);
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      check($sformatf("reset_busy%0d", s), 64'(get_busy(s)), 64'(0));
      check($sformatf("reset_done%0d", s), 64'(get_done(s)), 64'(0));
      check($sformatf("reset_dout%0d", s), 64'(get_dout(s)), 64'(0));
    end
    rst = 1'b0;

    run_op("asr4",      0, 2'b01, 8'd1, 8'h0A, 2, 8'h0D, 0);
    run_op("lsr4",      0, 2'b00, 8'd1, 8'h0A, 2, 8'h05, 0);
    run_op("ror4",      0, 2'b11, 8'd3, 8'h0A, 4, 8'h05, 0);
    run_op("lsl4",      0, 2'b10, 8'd2, 8'h0B, 3, 8'h0C, 0);
    run_op("amt0_4",    0, 2'b10, 8'd0, 8'h06, 1, 8'h06, 0);
    run_op("asr4_pos",  0, 2'b01, 8'd3, 8'h06, 4, 8'h00, 0);
    run_op("asr8_rep",  1, 2'b01, 8'd7, 8'h80, 8, 8'hFF, 3);
    run_op("lsl8",      1, 2'b10, 8'd7, 8'h81, 8, 8'h80, 0);
    run_op("ror8",      1, 2'b11, 8'd4, 8'h96, 5, 8'h69, 0);
    run_op("lsr8",      1, 2'b00, 8'd3, 8'hFF, 4, 8'h1F, 0);
    run_op("ror5_clamp",2, 2'b11, 8'd7, 8'h13, 5, 8'h07, 0);
    run_op("asr5_clamp",2, 2'b01, 8'd5, 8'h10, 5, 8'h1F, 0);
    run_op("lsr5_max",  2, 2'b00, 8'd4, 8'h1F, 5, 8'h01, 0);

    // Reset during the third SHIFT cycle of a 5-step operation.
    @(negedge clk);
    drive(1, 1'b1, 2'b00, 8'd5, 8'hA5);
    @(negedge clk);
    drive(1, 1'b0, 2'b00, 8'd5, 8'hA5);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_abort_busy", 64'(busy8), 64'(0));
    check("rst_abort_done", 64'(done8), 64'(0));
    check("rst_abort_dout", 64'(dout8), 64'(0));
    check("rst_other_dout", 64'(dout4), 64'(0));
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) dones++;
    end
    check("rst_no_done", 64'(dones), 64'(0));

    // start held high: accepts only in IDLE, so one operation every 3 cycles.
    @(negedge clk);
    drive(0, 1'b1, 2'b01, 8'd1, 8'h0A);
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done4) begin
        dones++;
        check($sformatf("b2b_dout_%0d", k), 64'(dout4), 64'(4'hD));
      end
    end
    drive(0, 1'b0, 2'b01, 8'd1, 8'h0A);
    check("b2b_done_count", 64'(dones), 64'(4));
    repeat (3) @(negedge clk);
    check("b2b_idle", 64'(busy4), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
